// File: rtl/lc3b_types.sv
// +--------------------------------------------------------------------------+
// | lc3b_types : shared LC-3b word/line types and pmem responder FSM states   |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   localparam int lc3b_offset_bits = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } pmem_state_t;

endpackage

`default_nettype wire

// File: rtl/pmem_array.sv
// +--------------------------------------------------------------------------+
// | pmem_array : 2^INDEX_BITS x 128-bit store, synchronous write, async read  |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module pmem_array
   import lc3b_types::*;
#(
   parameter int INDEX_BITS = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [INDEX_BITS-1:0] index,
   input  lc3b_line              wdata,
   output lc3b_line              rdata
);

   // No reset: contents survive reset and are undefined at power-up.
   lc3b_line mem [2**INDEX_BITS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[index] <= wdata;
      end
   end

   assign rdata = mem[index];

endmodule

`default_nettype wire

// File: rtl/pmem_responder.sv
// +--------------------------------------------------------------------------+
// | pmem_responder : line-granular physical memory with programmable latency  |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module pmem_responder
   import lc3b_types::*;
#(
   parameter int LATENCY    = 4,
   parameter int INDEX_BITS = 8
) (
   input  logic     clk,
   input  logic     reset_n,
   input  logic     pmem_read,
   input  logic     pmem_write,
   input  lc3b_word pmem_address,
   input  lc3b_line pmem_wdata,
   output lc3b_line pmem_rdata,
   output logic     pmem_resp,
   output logic     pmem_busy
);

   localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 1);

   pmem_state_t           state;
   logic [7:0]            count;
   logic [INDEX_BITS-1:0] index_q;
   lc3b_line              wdata_q;
   logic                  is_write;
   lc3b_line              array_rdata;
   logic                  array_we;
   logic                  unused_addr;

   assign unused_addr = ^{pmem_address[15:INDEX_BITS+lc3b_offset_bits],
                          pmem_address[lc3b_offset_bits-1:0]};

   // Commit happens on the same edge that raises pmem_resp; reset aborts it.
   assign array_we = reset_n && (state == BUSY) && (count == 8'd0) && is_write;

   pmem_array #(
      .INDEX_BITS (INDEX_BITS)
   ) u_array (
      .clk   (clk),
      .we    (array_we),
      .index (index_q),
      .wdata (wdata_q),
      .rdata (array_rdata)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         count      <= 8'd0;
         pmem_resp  <= 1'b0;
         pmem_rdata <= '0;
      end else begin
         pmem_resp  <= 1'b0;
         pmem_rdata <= '0;
         case (state)
            IDLE: begin
               if (pmem_read || pmem_write) begin
                  index_q  <= pmem_address[INDEX_BITS+lc3b_offset_bits-1:lc3b_offset_bits];
                  wdata_q  <= pmem_wdata;
                  is_write <= pmem_write;
                  count    <= COUNT_LOAD;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (count != 8'd0) begin
                  count <= count - 8'd1;
               end else begin
                  pmem_resp <= 1'b1;
                  if (!is_write) begin
                     pmem_rdata <= array_rdata;
                  end
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign pmem_busy = (state != IDLE);

endmodule

`default_nettype wire
